div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the execute stage of the 5-stage MIPS pipeline. It accepts a DIV/DIVU operation from E, runs a radix-2 restoring divider for 32 iterations, and stalls the pipeline front end while it runs. It then presents a 64-bit {remainder, quotient} result for the HI/LO write path (write_hilo). It also handles flush/annul, divide-by-zero and external back-pressure.

---
 rtl/cpu_defines.sv | 19 +
 rtl/div_datapath.sv | 56 +++++
 rtl/div_ctrl.sv | 121 ++++++++++++
 tb/tb_div_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defines.sv
// Shared definitions for the execute-stage divide sequencer: FSM state
// encodings, the iteration count and the HI/LO field offsets of the result.
package cpu_defines;

    typedef enum logic [1:0] {
        DIV_FREE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_t;

    // One restoring iteration per operand bit.
    localparam int DIV_CYCLES = 32;

    // Result layout: {remainder (HI), quotient (LO)}.
    localparam int HI_LSB = 32;
    localparam int LO_LSB = 0;

endpackage

// File: rtl/div_datapath.sv
// Radix-2 restoring divider datapath: {rem,quo} shift register, divisor
// register and trial subtractor. Operates on magnitudes only; the sign
// fix-up is done by the controller.
module div_datapath
    import cpu_defines::*;
#(
    parameter int DATA_W = DIV_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   trial;
    logic              borrow;

    // Trial subtraction of one restoring step; also feeds the controller so
    // it can capture the final step without waiting an extra cycle.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        partial  = {rem_q, quo_q[DATA_W-1]};
        trial    = partial - {1'b0, dvs_q};
        borrow   = trial[DATA_W];
        rem_next = borrow ? partial[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_next = {quo_q[DATA_W-2:0], ~borrow};
    end

    // Operand load on accept, one shift/subtract per step cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, regardless of statement order.
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage. Accepts an operation
// from E, stalls the front end while the restoring divider iterates, then
// presents the sign-corrected {remainder, quotient} for the HI/LO write.
module div_ctrl
    import cpu_defines::*;
#(
    parameter int DATA_W = DIV_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]   divisor,
    input  logic                annul,
    input  logic                hold,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                stall
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              q_neg;
    logic              r_neg;
    logic [DATA_W-1:0] zero_rem;
    logic              accept;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    // Two's-complement magnitude, only for signed operands with the MSB set.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                    input logic              is_signed);
        return (is_signed && x[DATA_W-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] x,
                                                     input logic              neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Accept and stall decode; reset also clears the stall request since no
    // operation can be accepted while it is asserted.
    always_comb begin
        accept = (state == DIV_FREE) && start && !annul;
        stall  = !rst && !annul &&
                 (((state == DIV_FREE) && start) || (state == DIV_ON) || (state == DIV_ZERO));
    end

    div_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state == DIV_ON),
        .dividend (magnitude(dividend, signed_div)),
        .divisor  (magnitude(divisor, signed_div)),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Sequencer FSM with registered ready/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_rem <= '0;
            result   <= '0;
            ready    <= 1'b0;
        end else if (annul && (state != DIV_FREE)) begin
            // Flush abandons the operation; the previous result is kept.
            state <= DIV_FREE;
            ready <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (accept) begin
                        q_neg    <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        r_neg    <= signed_div & dividend[DATA_W-1];
                        zero_rem <= dividend;
                        cnt      <= '0;
                        state    <= (divisor == '0) ? DIV_ZERO : DIV_ON;
                    end
                end
                DIV_ON: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Capture the last step directly from the subtractor.
                        result[HI_LSB +: DATA_W] <= apply_sign(rem_next, r_neg);
                        result[LO_LSB +: DATA_W] <= apply_sign(quo_next, q_neg);
                        ready <= 1'b1;
                        state <= DIV_END;
                    end
                end
                DIV_ZERO: begin
                    result[HI_LSB +: DATA_W] <= zero_rem;
                    result[LO_LSB +: DATA_W] <= '1;
                    ready <= 1'b1;
                    state <= DIV_END;
                end
                DIV_END: begin
                    if (!hold) begin
                        ready <= 1'b0;
                        state <= DIV_FREE;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= DIV_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall window, signed/unsigned
// results, divide-by-zero, annul, hold back-pressure and async reset.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        hold;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int checks = 0;
    int errors = 0;

    div_ctrl #(
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .hold       (hold),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one operation at the next falling edge, keep start high until
    // ready, then check latency, number of stall cycles and the result.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int   lat;
        int   stalls;
        logic seen;
        @(negedge clk);
        start = 1'b1; signed_div = s; dividend = a; divisor = b;
        #1;
        lat    = 0;
        stalls = stall ? 1 : 0;
        seen   = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk); #1;
            lat++;
            if (ready) seen = 1'b1;
            else if (stall) stalls++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
        chk({tag, " stall in END"}, 64'(stall), 64'd0);
        chk({tag, " result"}, result, exp_res);
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int rdy_cnt;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; dividend = '0; divisor = '0;
        annul = 1'b0; hold = 1'b0;
        #3;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Main function, several operand patterns.
        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        @(negedge clk); #1;
        chk("ready drops after END", 64'(ready), 64'd0);
        chk("result held after END", result, {32'd2, 32'd14});
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
        run_op("divu big", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, {32'd1, 32'h7FFF_FFFC});
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});

        // Divide by zero: raw dividend as remainder, all-ones quotient.
        run_op("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 2, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op("divu 5/0", 1'b0, 32'd5, 32'd0, 2, {32'd5, 32'hFFFF_FFFF});

        // annul together with start in FREE: nothing accepted.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dividend = 32'd100; divisor = 32'd7; signed_div = 1'b0;
        #1;
        chk("annul+start stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        chk("annul+start not accepted", 64'(stall), 64'd0);

        // annul at T+10 of DIVU 100/7.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7; signed_div = 1'b0;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        #1;
        chk("annul cycle stall", 64'(stall), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("after annul FREE", 64'(stall), 64'd0);
        rdy_cnt = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (ready) rdy_cnt++;
        end
        chk("annul no ready", 64'(rdy_cnt), 64'd0);
        chk("annul result kept", result, {32'd5, 32'hFFFF_FFFF});

        // hold for 3 cycles in END, then back-to-back DIVU 9/4.
        @(negedge clk);
        start = 1'b1; dividend = 32'd20; divisor = 32'd3; signed_div = 1'b0;
        #1;
        lat = 0;
        while (!ready && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        chk("hold op latency", 64'(lat), 64'd33);
        hold = 1'b1; start = 1'b0;
        chk("hold END1 ready", 64'(ready), 64'd1);
        chk("hold END1 result", result, {32'd2, 32'd6});
        repeat (2) begin
            @(negedge clk); #1;
            chk("hold ready stable", 64'(ready), 64'd1);
            chk("hold result stable", result, {32'd2, 32'd6});
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("release END4 ready", 64'(ready), 64'd1);
        chk("release END4 result", result, {32'd2, 32'd6});
        run_op("divu 9/4 b2b", 1'b0, 32'd9, 32'd4, 33, {32'd1, 32'd2});

        // Async reset in the middle of an operation (ON, cnt=15).
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7; signed_div = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        chk("pre-reset stall", 64'(stall), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst ready", 64'(ready), 64'd0);
        chk("async rst stall", 64'(stall), 64'd0);
        chk("async rst result", result, 64'd0);
        start = 1'b0;
        @(negedge clk); rst = 1'b0;
        run_op("divu 100/7 after rst", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
